// File: rtl/pattern_sel_ctrl.sv
// Debounced button / auto-cycle controller for the VGA pattern generator's pattern_select.
// Every pattern change is deferred to the start of vertical sync so a frame never tears.
module pattern_sel_ctrl #(
  parameter int unsigned DEBOUNCE_CYC  = 252000,
  parameter int unsigned AUTO_FRAMES   = 120,
  parameter bit          VS_ACTIVE_LOW = 1'b1,
  parameter int unsigned NUM_PATTERNS  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_next,
  input  logic       btn_auto,
  input  logic       i_vs,
  output logic [1:0] pattern_select,
  output logic       auto_mode,
  output logic       sel_changed
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DbW-1:0] DbMax    = DbW'(DEBOUNCE_CYC - 1);
  localparam logic [15:0]    FrameMax = 16'(AUTO_FRAMES - 1);
  localparam logic [1:0]     PatMax   = 2'(NUM_PATTERNS - 1);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  // Bit 0 is btn_next, bit 1 is btn_auto.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q, level_q, level_dly_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [1:0]     press;
  logic           next_press, auto_press;

  logic           vs_act, vs_act_d_q, frame_edge;
  logic [15:0]    frame_cnt_q;
  logic           auto_req, request;

  state_e         state_q;
  logic [1:0]     pattern_q;
  logic           auto_mode_q, sel_changed_q;

  assign btn_raw = {btn_auto, btn_next};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_dly_q <= level_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbMax) begin
          level_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign press      = level_q & ~level_dly_q;
  assign next_press = press[0];
  assign auto_press = press[1];

  assign vs_act     = VS_ACTIVE_LOW ? ~i_vs : i_vs;
  assign frame_edge = vs_act & ~vs_act_d_q;

  // Raised on the frame edge that completes the interval; lands one frame later.
  assign auto_req = auto_mode_q & frame_edge & (frame_cnt_q == FrameMax);
  assign request  = next_press | auto_req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_act_d_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vs_act_d_q <= vs_act;
      if (next_press || !auto_mode_q) begin
        frame_cnt_q <= '0;
      end else if (frame_edge) begin
        frame_cnt_q <= auto_req ? 16'd0 : frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      pattern_q     <= '0;
      auto_mode_q   <= 1'b0;
      sel_changed_q <= 1'b0;
    end else begin
      sel_changed_q <= 1'b0;
      if (auto_press) auto_mode_q <= ~auto_mode_q;
      unique case (state_q)
        StIdle: begin
          if (request) state_q <= StPending;
        end
        StPending: begin
          // Requests arriving while pending merge into this single advance.
          if (frame_edge) begin
            pattern_q     <= (pattern_q == PatMax) ? 2'd0 : pattern_q + 2'd1;
            sel_changed_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pattern_select = pattern_q;
  assign auto_mode      = auto_mode_q;
  assign sel_changed    = sel_changed_q;

endmodule
